// File: rtl/pc_sequencer.sv
// Program-counter sequencer with debug run/step/halt control and next-PC selection.
// Define PC_SEQ_CYCLE_CNT_EN to build the enabled-cycle counter; otherwise o_cycle_count reads 0.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_halt_req,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_jump,
  input  logic [PC_WIDTH-1:0] i_jump_target,
  input  logic                i_halt_instr,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_enable,
  output logic                o_pc_write,
  output logic                o_if_flush,
  output logic [1:0]          o_state,
  output logic [31:0]         o_cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] branch_aligned;
  logic [PC_WIDTH-1:0] jump_aligned;
  logic                enable;
  logic                pc_write;

  // Targets are word aligned, so their two low bits are dropped by design.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^{i_branch_target[1:0], i_jump_target[1:0]};

  assign branch_aligned = {i_branch_target[PC_WIDTH-1:2], 2'b00};
  assign jump_aligned   = {i_jump_target[PC_WIDTH-1:2], 2'b00};
  assign pc_plus4       = pc_q + PC_WIDTH'(4);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_run) begin
          state_d = RUN;
        end else if (i_step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (i_halt_instr) begin
          state_d = HALTED;
        end else if (i_halt_req) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (i_halt_instr) begin
          state_d = HALTED;
        end else begin
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // A taken branch beats a stall, a jump does not; a HALT in fetch freezes the PC.
  always_comb begin
    enable   = (state_q == RUN) || (state_q == STEP);
    pc_write = enable && !i_halt_instr && (i_branch_taken || !i_stall);
    pc_d     = pc_q;
    if (pc_write) begin
      if (i_branch_taken) begin
        pc_d = branch_aligned;
      end else if (i_jump) begin
        pc_d = jump_aligned;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  assign o_pc       = pc_q;
  assign o_enable   = enable;
  assign o_pc_write = pc_write;
  assign o_if_flush = pc_write && (i_branch_taken || i_jump);
  assign o_state    = state_q;

`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (enable) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cycle_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  assign o_cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a 32-bit and an 8-bit instance share one stimulus stream
// and are compared every cycle against a behavioural model of the debug/PC rules.
module tb_pc_sequencer;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_HALTED = 3;
  localparam logic [7:0] RESET_PC8 = 8'h10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN, run, step, haltReq, stall, branchTaken, jump, haltInstr;
  logic [31:0] branchTarget, jumpTarget;

  logic [31:0] pc32, count32, count8;
  logic [7:0]  pc8;
  logic        enable32, pcWrite32, flush32, enable8, pcWrite8, flush8;
  logic [1:0]  state32, state8;

  pc_sequencer dut32 (
    .i_clk(clk), .i_reset(resetN), .i_run(run), .i_step(step), .i_halt_req(haltReq),
    .i_stall(stall), .i_branch_taken(branchTaken), .i_branch_target(branchTarget),
    .i_jump(jump), .i_jump_target(jumpTarget), .i_halt_instr(haltInstr),
    .o_pc(pc32), .o_enable(enable32), .o_pc_write(pcWrite32), .o_if_flush(flush32),
    .o_state(state32), .o_cycle_count(count32)
  );

  pc_sequencer #(.PC_WIDTH(8), .RESET_PC(RESET_PC8)) dut8 (
    .i_clk(clk), .i_reset(resetN), .i_run(run), .i_step(step), .i_halt_req(haltReq),
    .i_stall(stall), .i_branch_taken(branchTaken), .i_branch_target(branchTarget[7:0]),
    .i_jump(jump), .i_jump_target(jumpTarget[7:0]), .i_halt_instr(haltInstr),
    .o_pc(pc8), .o_enable(enable8), .o_pc_write(pcWrite8), .o_if_flush(flush8),
    .o_state(state8), .o_cycle_count(count8)
  );

  int testCount = 0;
  int failCount = 0;

  // Reference model state, advanced once per rising edge.
  int          mdlMode  = M_IDLE;
  logic [31:0] mdlPc32  = '0;
  logic [7:0]  mdlPc8   = '0;
  logic [31:0] mdlCnt   = '0;
  bit          mdlValid = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expectedCount();
`ifdef PC_SEQ_CYCLE_CNT_EN
    return mdlCnt;
`else
    return 32'd0;
`endif
  endfunction

  // Drives one cycle of inputs, checks both instances before the edge, then advances the model.
  task automatic applyStimulus(input logic rN, input logic r, input logic s, input logic hr,
                               input logic st, input logic bt, input logic [31:0] btgt,
                               input logic jp, input logic [31:0] jtgt, input logic hi);
    logic        en, wr, fl;
    logic [31:0] next32;
    logic [7:0]  next8;
    resetN = rN; run = r; step = s; haltReq = hr; stall = st;
    branchTaken = bt; branchTarget = btgt; jump = jp; jumpTarget = jtgt; haltInstr = hi;
    #1;
    en = (mdlMode == M_RUN) || (mdlMode == M_STEP);
    wr = en && !hi && (bt || !st);
    fl = wr && (bt || jp);
    if (mdlValid) begin
      checkOutput("state32", 32'(state32), 32'(mdlMode));
      checkOutput("state8", 32'(state8), 32'(mdlMode));
      checkOutput("enable32", 32'(enable32), 32'(en));
      checkOutput("enable8", 32'(enable8), 32'(en));
      checkOutput("pcWrite32", 32'(pcWrite32), 32'(wr));
      checkOutput("pcWrite8", 32'(pcWrite8), 32'(wr));
      checkOutput("flush32", 32'(flush32), 32'(fl));
      checkOutput("flush8", 32'(flush8), 32'(fl));
      checkOutput("pc32", pc32, mdlPc32);
      checkOutput("pc8", 32'(pc8), 32'(mdlPc8));
      checkOutput("count32", count32, expectedCount());
      checkOutput("count8", count8, expectedCount());
    end
    @(posedge clk);
    if (!rN) begin
      mdlMode  = M_IDLE;
      mdlPc32  = 32'd0;
      mdlPc8   = RESET_PC8;
      mdlCnt   = 32'd0;
      mdlValid = 1'b1;
    end else if (mdlValid) begin
      if (en) mdlCnt = mdlCnt + 32'd1;
      if (wr) begin
        if (bt) begin
          next32 = btgt & ~32'd3;
          next8  = btgt[7:0] & ~8'd3;
        end else if (jp) begin
          next32 = jtgt & ~32'd3;
          next8  = jtgt[7:0] & ~8'd3;
        end else begin
          next32 = mdlPc32 + 32'd4;
          next8  = 8'((int'(mdlPc8) + 4) % 256);
        end
        mdlPc32 = next32;
        mdlPc8  = next8;
      end
      if (mdlMode == M_IDLE) begin
        if (r) mdlMode = M_RUN;
        else if (s) mdlMode = M_STEP;
      end else if (mdlMode == M_RUN) begin
        if (hi) mdlMode = M_HALTED;
        else if (hr) mdlMode = M_IDLE;
      end else if (mdlMode == M_STEP) begin
        mdlMode = hi ? M_HALTED : M_IDLE;
      end
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0);
  endtask

  initial begin
    resetN = 1'b0; run = 0; step = 0; haltReq = 0; stall = 0;
    branchTaken = 0; branchTarget = '0; jump = 0; jumpTarget = '0; haltInstr = 0;
    @(negedge clk);

    applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    applyStimulus(0, 1, 0, 1, 1, 1, 32'h40, 1, 32'h80, 1);
    checkOutput("reset_pc32", pc32, 32'd0);
    checkOutput("reset_pc8", 32'(pc8), 32'h10);

    repeat (5) idleCycle();
    checkOutput("idle_pc32", pc32, 32'd0);
    checkOutput("idle_state", 32'(state32), 32'd0);
    checkOutput("idle_enable", 32'(enable32), 32'd0);

    applyStimulus(1, 1, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    checkOutput("run_pc_4", pc32, 32'd4);
    idleCycle();
    checkOutput("run_pc_8", pc32, 32'd8);
    applyStimulus(1, 0, 0, 1, 0, 0, 32'd0, 0, 32'd0, 0);
    checkOutput("run_pc_12", pc32, 32'd12);
    checkOutput("halt_req_idle", 32'(state32), 32'd0);
    idleCycle();
    checkOutput("idle_hold_12", pc32, 32'd12);

    applyStimulus(1, 0, 1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    checkOutput("step_state", 32'(state32), 32'd2);
    idleCycle();
    checkOutput("step_pc_16", pc32, 32'd16);
    checkOutput("step_back_idle", 32'(state32), 32'd0);
`ifdef PC_SEQ_CYCLE_CNT_EN
    checkOutput("step_count", count32, 32'd4);
`else
    checkOutput("step_count", count32, 32'd0);
`endif

    applyStimulus(1, 1, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 32'd0, 1, 32'h100, 0);
    checkOutput("stall_jump_hold", pc32, 32'd16);
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h203, 0, 32'd0, 0);
    checkOutput("stall_branch_pc", pc32, 32'h200);

    applyStimulus(1, 0, 0, 0, 0, 1, 32'hFB, 0, 32'd0, 0);
    checkOutput("branch_align8", 32'(pc8), 32'hF8);
    idleCycle();
    checkOutput("pc8_fc", 32'(pc8), 32'hFC);
    idleCycle();
    checkOutput("pc8_wrap", 32'(pc8), 32'h00);
    checkOutput("pc32_no_wrap", pc32, 32'h100);

    applyStimulus(1, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1);
    checkOutput("halted_state", 32'(state8), 32'd3);
    checkOutput("halted_pc8", 32'(pc8), 32'h00);
    repeat (3) applyStimulus(1, 1, 1, 0, 0, 1, 32'h44, 1, 32'h88, 0);
    checkOutput("halted_frozen", 32'(pc8), 32'h00);
    checkOutput("halted_stays", 32'(state32), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    checkOutput("post_halt_reset8", 32'(pc8), 32'h10);
    checkOutput("post_halt_state", 32'(state8), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) >= 3,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 8,
                    $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 15,
                    $urandom(),
                    $urandom_range(0, 99) < 15,
                    $urandom(),
                    $urandom_range(0, 99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, meaning program counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 The block SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port i_run  input  1  debug request to run continuously.
REQ-006 The block SHALL have port i_step  input  1  debug request to advance exactly one cycle.
REQ-007 The block SHALL have port i_halt_req  input  1  debug request to pause.
REQ-008 The block SHALL have port i_stall  input  1  hazard-unit request to freeze the PC.
REQ-009 The block SHALL have port i_branch_taken  input  1  resolved taken branch.
REQ-010 The block SHALL have port i_branch_target  input  PC_WIDTH  branch destination.
REQ-011 The block SHALL have port i_jump  input  1  jump decoded.
REQ-012 The block SHALL have port i_jump_target  input  PC_WIDTH  jump destination.
REQ-013 The block SHALL have port i_halt_instr  input  1  HALT instruction present in fetch.
REQ-014 The block SHALL have port o_pc  output  PC_WIDTH  registered current PC.
REQ-015 The block SHALL have port o_enable  output  1  global pipeline enable.
REQ-016 The block SHALL have port o_pc_write  output  1  PC update strobe for the current cycle.
REQ-017 The block SHALL have port o_if_flush  output  1  flush the IF/ID register.
REQ-018 The block SHALL have port o_state  output  2  FSM state encoding.
REQ-019 The block SHALL have port o_cycle_count  output  32  count of enabled cycles.

Function
REQ-020 The FSM SHALL have states IDLE=0, RUN=1, STEP=2 and HALTED=3, registered, with Moore outputs.
- IDLE: i_run goes to RUN; otherwise i_step goes to STEP; i_run and i_step together go to RUN.
- RUN: i_halt_instr goes to HALTED; otherwise i_halt_req goes to IDLE; i_step is ignored.
- STEP: i_halt_instr goes to HALTED; otherwise IDLE unconditionally after one cycle.
- HALTED: exits only on reset.
REQ-021 o_enable SHALL be 1 exactly in the RUN and STEP states.
REQ-022 Next-PC priority SHALL be: i_branch_taken, then i_jump, then o_pc+4.
REQ-023 o_pc+4 SHALL wrap modulo 2^PC_WIDTH.
REQ-024 Branch and jump targets SHALL have bits [1:0] forced to 0.
REQ-025 o_pc_write SHALL equal o_enable & !i_halt_instr & (i_branch_taken | !i_stall).
- A taken branch overrides the stall.
- A jump does not override the stall.
REQ-026 When o_pc_write=1, o_pc SHALL take the selected next-PC at the next rising edge (latency 1 cycle); otherwise o_pc SHALL hold.
REQ-027 o_if_flush SHALL equal o_pc_write & (i_branch_taken | i_jump), combinational.
REQ-028 On i_halt_instr while enabled, o_pc SHALL hold the HALT address.
REQ-029 All inputs SHALL be ignored while the FSM is in HALTED or IDLE, except i_run and i_step in IDLE.

Reset
REQ-030 When i_reset=0 at a rising edge, the block SHALL set state=IDLE, o_pc=RESET_PC and o_cycle_count=0.
- Reset SHALL take effect in any state, including mid-RUN or mid-STEP.
- Reset SHALL override all other inputs.
REQ-031 After reset, the block SHALL drive o_enable=0, o_pc_write=0, o_if_flush=0 and o_state=0.

Configuration
REQ-032 The macro PC_SEQ_CYCLE_CNT_EN SHALL control the cycle counter.
- When defined, o_cycle_count SHALL increment by 1 each cycle o_enable=1 and wrap at 2^32.
- When undefined, o_cycle_count SHALL be tied to 0 and no counter logic is synthesized.

Verification
REQ-033 Reset, then hold i_run=0 and i_step=0 for 5 cycles -> o_pc=0, o_state=0, o_enable=0.
REQ-034 Pulse i_run, no branch or jump, 3 cycles -> o_pc=4, 8, 12; then i_halt_req -> state IDLE and o_pc holds 12.
REQ-035 From IDLE at o_pc=12, pulse i_step once -> exactly one update to 16, state returns to IDLE, o_cycle_count=4 when PC_SEQ_CYCLE_CNT_EN is defined, 0 otherwise.
REQ-036 In RUN, drive i_stall=1 with i_jump=1 and target 0x100 -> o_pc holds; then i_stall=1 with i_branch_taken=1 and target 0x203 -> o_pc=0x200 and o_if_flush=1.
REQ-037 Set PC_WIDTH=8 and run to o_pc=0xFC -> next o_pc=0x00; assert i_halt_instr -> HALTED and o_pc frozen; i_run ignored until reset, after which o_pc=RESET_PC.
